// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32 pipeline: stalls, flushes, EX forwarding selects,
// the ID write-back bypass and stall/flush performance counters.
module hazard_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             cpu_clk,
   input  logic             cpu_rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rd,
   input  logic             id_rf_we,
   input  logic             id_is_load,
   input  logic             ex_redirect,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       ex_fwd_a,
   output logic [1:0]       ex_fwd_b,
   output logic             id_byp_a,
   output logic             id_byp_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       we;
      logic       ld;
   } slot_t;

   slot_t            ex_q, ex_d, mem_q, wb_q;
   logic             id_bub_q, id_bub_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic id_ok, load_use;
   logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;

   function automatic logic slot_match(slot_t s, logic [4:0] rs, logic used);
      return s.v & s.we & (s.rd != 5'd0) & (s.rd == rs) & used;
   endfunction

   // Youngest producer first; a load still in EX cannot forward its data yet.
   function automatic logic [1:0] fwd_sel(logic ex_m, logic ex_ld, logic mem_m);
      if (ex_m && !ex_ld) return 2'd1;
      else if (mem_m)     return 2'd2;
      else                return 2'd0;
   endfunction

   always_comb begin
      id_ok    = id_valid & ~id_bub_q;
      ex_m1    = slot_match(ex_q, id_rs1, id_rs1_used);
      ex_m2    = slot_match(ex_q, id_rs2, id_rs2_used);
      mem_m1   = slot_match(mem_q, id_rs1, id_rs1_used);
      mem_m2   = slot_match(mem_q, id_rs2, id_rs2_used);
      wb_m1    = slot_match(wb_q, id_rs1, id_rs1_used);
      wb_m2    = slot_match(wb_q, id_rs2, id_rs2_used);
      load_use = id_ok & ex_q.ld & (ex_m1 | ex_m2);

      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end

      id_byp_a = wb_m1 & ~ex_m1 & ~mem_m1;
      id_byp_b = wb_m2 & ~ex_m2 & ~mem_m2;
   end

   always_comb begin
      ex_d        = id_ex_flush ? '0 : '{v: id_ok, rd: id_rd, we: id_rf_we, ld: id_is_load};
      fwd_a_d     = id_ex_flush ? 2'd0 : fwd_sel(ex_m1, ex_q.ld, mem_m1);
      fwd_b_d     = id_ex_flush ? 2'd0 : fwd_sel(ex_m2, ex_q.ld, mem_m2);
      id_bub_d    = if_id_stall ? id_bub_q : if_id_flush;
      stall_cnt_d = pc_stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = ex_redirect ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         id_bub_q    <= 1'b1;
         fwd_a_q     <= 2'd0;
         fwd_b_q     <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= ex_q;
         wb_q        <= mem_q;
         id_bub_q    <= id_bub_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_fwd_a  = fwd_a_q;
   assign ex_fwd_b  = fwd_b_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios, then random traffic
// checked against an in-flight instruction list model.
module tb_hazard_ctrl;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst = 1'b1;
   logic        id_valid, id_rs1_used, id_rs2_used, id_rf_we, id_is_load, ex_redirect;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_byp_a, id_byp_b;
   logic [1:0]  ex_fwd_a, ex_fwd_b;
   logic [31:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.CNT_W(32)) dut (
      .cpu_clk    (cpu_clk),
      .cpu_rst    (cpu_rst),
      .id_valid   (id_valid),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used),
      .id_rd      (id_rd),
      .id_rf_we   (id_rf_we),
      .id_is_load (id_is_load),
      .ex_redirect(ex_redirect),
      .pc_stall   (pc_stall),
      .if_id_stall(if_id_stall),
      .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush),
      .ex_fwd_a   (ex_fwd_a),
      .ex_fwd_b   (ex_fwd_b),
      .id_byp_a   (id_byp_a),
      .id_byp_b   (id_byp_b),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Instructions that left ID: index 0 is in EX, 1 in MEM, 2 in WB.
   typedef struct {
      bit v;
      int rd;
      bit we;
      bit ld;
   } instr_t;

   instr_t      pipe[3];
   bit          m_bub;
   int          m_fwd_a, m_fwd_b;
   int unsigned m_scnt, m_fcnt;
   bit          m_stall, m_iff, m_exf, m_byp_a, m_byp_b, m_ok;
   int          m_sel_a, m_sel_b;

   int n_vec = 0;
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit writes(int k, int rs, bit used);
      return used && pipe[k].v && pipe[k].we && pipe[k].rd != 0 && pipe[k].rd == rs;
   endfunction

   function automatic int operand_src(int rs, bit used);
      if (writes(0, rs, used)) return pipe[0].ld ? (writes(1, rs, used) ? 2 : 0) : 1;
      if (writes(1, rs, used)) return 2;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) pipe[k] = '{v: 0, rd: 0, we: 0, ld: 0};
      m_bub   = 1;
      m_fwd_a = 0;
      m_fwd_b = 0;
      m_scnt  = 0;
      m_fcnt  = 0;
   endtask

   task automatic model_comb();
      bit lu;
      int r1, r2;
      r1      = int'(id_rs1);
      r2      = int'(id_rs2);
      m_ok    = id_valid && !m_bub;
      lu      = m_ok && pipe[0].ld && (writes(0, r1, id_rs1_used) || writes(0, r2, id_rs2_used));
      m_iff   = ex_redirect;
      m_stall = !ex_redirect && lu;
      m_exf   = ex_redirect || lu;
      m_byp_a = writes(2, r1, id_rs1_used) && !writes(0, r1, id_rs1_used)
                && !writes(1, r1, id_rs1_used);
      m_byp_b = writes(2, r2, id_rs2_used) && !writes(0, r2, id_rs2_used)
                && !writes(1, r2, id_rs2_used);
      m_sel_a = operand_src(r1, id_rs1_used);
      m_sel_b = operand_src(r2, id_rs2_used);
   endtask

   task automatic model_edge();
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (m_exf) pipe[0] = '{v: 0, rd: 0, we: 0, ld: 0};
      else pipe[0] = '{v: m_ok, rd: int'(id_rd), we: id_rf_we, ld: id_is_load};
      m_fwd_a = m_exf ? 0 : m_sel_a;
      m_fwd_b = m_exf ? 0 : m_sel_b;
      if (!m_stall) m_bub = m_iff;
      if (m_stall) m_scnt++;
      if (m_iff) m_fcnt++;
   endtask

   // Drive one ID-stage instruction and check the combinational outputs.
   task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit we, input bit ld, input bit redir);
      id_valid    = v;
      id_rs1      = 5'(rs1);
      id_rs1_used = u1;
      id_rs2      = 5'(rs2);
      id_rs2_used = u2;
      id_rd       = 5'(rd);
      id_rf_we    = we;
      id_is_load  = ld;
      ex_redirect = redir;
      n_vec++;
      #1;
      model_comb();
      check("pc_stall", 32'(pc_stall), 32'(m_stall));
      check("if_id_stall", 32'(if_id_stall), 32'(m_stall));
      check("if_id_flush", 32'(if_id_flush), 32'(m_iff));
      check("id_ex_flush", 32'(id_ex_flush), 32'(m_exf));
      check("id_byp_a", 32'(id_byp_a), 32'(m_byp_a));
      check("id_byp_b", 32'(id_byp_b), 32'(m_byp_b));
   endtask

   // Clock edge, then check the registered outputs; returns just after the falling edge.
   task automatic tick();
      @(posedge cpu_clk);
      model_edge();
      #1;
      check("ex_fwd_a", 32'(ex_fwd_a), 32'(m_fwd_a));
      check("ex_fwd_b", 32'(ex_fwd_b), 32'(m_fwd_b));
      check("stall_cnt", stall_cnt, m_scnt);
      check("flush_cnt", flush_cnt, m_fcnt);
      @(negedge cpu_clk);
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic do_reset();
      cpu_rst = 1'b1;
      #1;
      model_reset();
      check("rst_pc_stall", 32'(pc_stall), 32'd0);
      check("rst_fwd_a", 32'(ex_fwd_a), 32'd0);
      check("rst_fwd_b", 32'(ex_fwd_b), 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_flush_cnt", flush_cnt, 32'd0);
      @(posedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge cpu_clk);
      do_reset();
      // First ID instruction after reset is a bubble.
      drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
      check("bubble_after_reset", 32'(m_ok), 32'd0);
      tick();

      // add x5,x1,x2 ; sub x6,x5,x3
      drive(1, 1, 1, 2, 1, 5, 1, 0, 0); tick();
      drive(1, 5, 1, 3, 1, 6, 1, 0, 0);
      check("fwd_no_stall", 32'(pc_stall), 32'd0);
      tick();
      check("fwd_sub_ex", 32'(ex_fwd_a), 32'd1);

      // lw x7,0(x0) ; add x8,x7,x7
      do_reset();
      nop();
      drive(1, 0, 1, 0, 0, 7, 1, 1, 0); tick();
      drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
      check("lu_stall", 32'({pc_stall, if_id_stall, id_ex_flush}), 32'b111);
      tick();
      check("lu_stall_cnt", stall_cnt, 32'd1);
      drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
      check("lu_no_second", 32'(pc_stall), 32'd0);
      tick();
      check("lu_fwd_ab", 32'({ex_fwd_a, ex_fwd_b}), 32'b1010);

      // producer of x9, two independents, consumer of x9
      drive(1, 1, 1, 0, 0, 9, 1, 0, 0); tick();
      drive(1, 2, 1, 0, 0, 10, 1, 0, 0); tick();
      drive(1, 3, 1, 0, 0, 11, 1, 0, 0); tick();
      drive(1, 9, 1, 4, 1, 12, 1, 0, 0);
      check("byp_a", 32'(id_byp_a), 32'd1);
      check("byp_no_stall", 32'(pc_stall), 32'd0);
      tick();

      // redirect in the same cycle as a load-use match
      do_reset();
      nop();
      drive(1, 0, 1, 0, 0, 7, 1, 1, 0); tick();
      drive(1, 7, 1, 0, 0, 8, 1, 0, 1);
      check("redir_flush", 32'({if_id_flush, id_ex_flush, pc_stall}), 32'b110);
      tick();
      check("redir_flush_cnt", flush_cnt, 32'd1);
      check("redir_stall_cnt", stall_cnt, 32'd0);
      drive(1, 7, 1, 0, 0, 8, 1, 0, 0);
      check("redir_after", 32'(pc_stall), 32'd0);
      tick();

      // lw x0,0(x0) ; add x1,x0,x0
      drive(1, 0, 1, 0, 0, 0, 1, 1, 0); tick();
      drive(1, 0, 1, 0, 1, 1, 1, 0, 0);
      check("x0_no_stall", 32'(pc_stall), 32'd0);
      tick();
      check("x0_fwd", 32'({ex_fwd_a, ex_fwd_b}), 32'd0);

      // reset in the middle of a load-use stall
      drive(1, 0, 1, 0, 0, 7, 1, 1, 0); tick();
      drive(1, 7, 1, 0, 0, 8, 1, 0, 0);
      check("pre_rst_stall", 32'(pc_stall), 32'd1);
      do_reset();
      check("post_rst_stall_cnt", stall_cnt, 32'd0);
      drive(1, 7, 1, 0, 0, 8, 1, 0, 0);
      check("post_rst_no_stall", 32'(pc_stall), 32'd0);
      tick();

      // random traffic over a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(9, 0) < 8), $urandom_range(7, 0), $urandom_range(1, 0),
               $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(7, 0),
               $urandom_range(1, 0), ($urandom_range(9, 0) < 3), ($urandom_range(9, 0) == 0));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
